ram_port_arbiter: RTL and testbench

//  Shares the single-port 16x8 program/data RAM between two requesters: the TRISC CPU datapath
//  (fetch/operand/store) and the front-panel loader (switch DataIn + address generator).

---
 rtl/trisc_pkg.sv | 13 +
 rtl/arb_wait_ctr.sv | 37 +++
 rtl/ram_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trisc_pkg.sv
// Shared types and widths for the TRISC RAM port arbiter slice.
package trisc_pkg;

  localparam int unsigned TRISC_ADDR_W = 4;
  localparam int unsigned TRISC_DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_LDR  = 2'b10
  } owner_t;

endpackage

// File: rtl/arb_wait_ctr.sv
// Saturating 4-bit count of consecutive lost arbitration cycles for one requester.
module arb_wait_ctr
  import trisc_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic wait_hit_o
);

  localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'h0;
    end else if (inc_i && (cnt_q != 4'hF)) begin
      cnt_d = cnt_q + 4'h1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'h0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wait_hit_o = (cnt_q >= MaxWaitC);

endmodule

// File: rtl/ram_port_arbiter.sv
// Cycle-by-cycle arbiter sharing the single-port program/data RAM between CPU and loader.
// Optional macro TRISC_ARB_LOCK_EN adds CpuLock for atomic CPU read-modify-write sequences.
module ram_port_arbiter
  import trisc_pkg::*;
#(
  parameter int unsigned ADDR_W   = TRISC_ADDR_W,
  parameter int unsigned DATA_W   = TRISC_DATA_W,
  parameter int unsigned MAX_WAIT = 3,
  parameter int unsigned PRIO_LDR = 0
) (
  input  logic              SysClock,
  input  logic              ResetN,
  input  logic              CpuReq,
  input  logic              CpuWe,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWdata,
`ifdef TRISC_ARB_LOCK_EN
  input  logic              CpuLock,
`endif
  output logic              CpuGnt,
  output logic              CpuRvalid,
  output logic [DATA_W-1:0] CpuRdata,
  input  logic              LdrReq,
  input  logic              LdrWe,
  input  logic [ADDR_W-1:0] LdrAddr,
  input  logic [DATA_W-1:0] LdrWdata,
  output logic              LdrGnt,
  output logic              LdrRvalid,
  output logic [DATA_W-1:0] LdrRdata,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [DATA_W-1:0] RamData,
  output logic              RamWren,
  output logic              RamEn,
  input  logic [DATA_W-1:0] RamQ,
  output logic [1:0]        Owner
);

  owner_t            owner_q, owner_d;
  logic              cpu_rv_q, ldr_rv_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic cpu_hit, ldr_hit, lock_hold;
  logic cpu_win, ldr_win;
  logic cpu_gnt, ldr_gnt;

  arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_cpu_wait (
    .clk_i      (SysClock),
    .rst_ni     (ResetN),
    .inc_i      (CpuReq & ~cpu_gnt),
    .clr_i      (~CpuReq | cpu_gnt),
    .wait_hit_o (cpu_hit)
  );

  arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_ldr_wait (
    .clk_i      (SysClock),
    .rst_ni     (ResetN),
    .inc_i      (LdrReq & ~ldr_gnt),
    .clr_i      (~LdrReq | ldr_gnt),
    .wait_hit_o (ldr_hit)
  );

`ifdef TRISC_ARB_LOCK_EN
  // Lock only bites while the CPU still owns the port and keeps requesting.
  assign lock_hold = (owner_q == OWN_CPU) & CpuLock & CpuReq;
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    cpu_win = 1'b0;
    ldr_win = 1'b0;
    if (CpuReq && LdrReq) begin
      if (lock_hold) begin
        cpu_win = 1'b1;
      end else if (ldr_hit) begin
        ldr_win = 1'b1;
      end else if (cpu_hit) begin
        cpu_win = 1'b1;
      end else if (PRIO_LDR != 0) begin
        ldr_win = 1'b1;
      end else begin
        cpu_win = 1'b1;
      end
    end else begin
      cpu_win = CpuReq;
      ldr_win = LdrReq;
    end
  end

  // Grants are masked during reset so no RAM access can slip through.
  assign cpu_gnt = cpu_win & ResetN;
  assign ldr_gnt = ldr_win & ResetN;

  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_gnt) begin
      owner_d = OWN_CPU;
    end else if (ldr_gnt) begin
      owner_d = OWN_LDR;
    end
  end

  always_ff @(posedge SysClock or negedge ResetN) begin
    if (!ResetN) begin
      owner_q  <= OWN_NONE;
      cpu_rv_q <= 1'b0;
      ldr_rv_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      owner_q  <= owner_d;
      cpu_rv_q <= cpu_gnt & ~CpuWe;
      ldr_rv_q <= ldr_gnt & ~LdrWe;
      if (cpu_gnt) begin
        addr_q <= CpuAddr;
        data_q <= CpuWdata;
      end else if (ldr_gnt) begin
        addr_q <= LdrAddr;
        data_q <= LdrWdata;
      end
    end
  end

  always_comb begin
    RamEn   = cpu_gnt | ldr_gnt;
    RamWren = (cpu_gnt & CpuWe) | (ldr_gnt & LdrWe);
    RamAddr = addr_q;
    RamData = data_q;
    if (cpu_gnt) begin
      RamAddr = CpuAddr;
      RamData = CpuWdata;
    end else if (ldr_gnt) begin
      RamAddr = LdrAddr;
      RamData = LdrWdata;
    end
  end

  assign CpuGnt    = cpu_gnt;
  assign LdrGnt    = ldr_gnt;
  assign CpuRvalid = cpu_rv_q;
  assign LdrRvalid = ldr_rv_q;
  assign CpuRdata  = RamQ;
  assign LdrRdata  = RamQ;
  assign Owner     = owner_q;

  a_one_grant : assert property (@(posedge SysClock) disable iff (!ResetN) !(CpuGnt && LdrGnt));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter with a per-cycle behavioural model and directed checks.
module tb_ram_port_arbiter;
  import trisc_pkg::*;

  localparam int unsigned MW = 3;
  localparam int unsigned PL = 0;

  logic       SysClock = 1'b0;
  logic       ResetN   = 1'b1;
  logic       CpuReq = 0, CpuWe = 0, LdrReq = 0, LdrWe = 0;
  logic [3:0] CpuAddr = 0, LdrAddr = 0;
  logic [7:0] CpuWdata = 0, LdrWdata = 0;
  logic       cpu_lock = 0;
  logic       CpuGnt, CpuRvalid, LdrGnt, LdrRvalid, RamWren, RamEn;
  logic [7:0] CpuRdata, LdrRdata, RamData, RamQ;
  logic [3:0] RamAddr;
  logic [1:0] Owner;

  always #5 SysClock = ~SysClock;

  ram_port_arbiter #(
    .ADDR_W   (4),
    .DATA_W   (8),
    .MAX_WAIT (MW),
    .PRIO_LDR (PL)
  ) dut (
    .SysClock  (SysClock),
    .ResetN    (ResetN),
    .CpuReq    (CpuReq),
    .CpuWe     (CpuWe),
    .CpuAddr   (CpuAddr),
    .CpuWdata  (CpuWdata),
`ifdef TRISC_ARB_LOCK_EN
    .CpuLock   (cpu_lock),
`endif
    .CpuGnt    (CpuGnt),
    .CpuRvalid (CpuRvalid),
    .CpuRdata  (CpuRdata),
    .LdrReq    (LdrReq),
    .LdrWe     (LdrWe),
    .LdrAddr   (LdrAddr),
    .LdrWdata  (LdrWdata),
    .LdrGnt    (LdrGnt),
    .LdrRvalid (LdrRvalid),
    .LdrRdata  (LdrRdata),
    .RamAddr   (RamAddr),
    .RamData   (RamData),
    .RamWren   (RamWren),
    .RamEn     (RamEn),
    .RamQ      (RamQ),
    .Owner     (Owner)
  );

  // RAM macro stand-in: registered read, 1-cycle latency.
  logic [7:0] ram_mem [16];
  logic [7:0] ram_q;
  always @(posedge SysClock) begin
    if (RamEn) begin
      if (RamWren) ram_mem[RamAddr] <= RamData;
      ram_q <= ram_mem[RamAddr];
    end
  end
  assign RamQ = ram_q;

  // Reference model state
  int         cpu_wait, ldr_wait, exp_owner;
  bit         exp_cpu_rv, exp_ldr_rv;
  logic [7:0] exp_rd;
  logic [3:0] last_addr;
  logic [7:0] last_data;
  logic [7:0] shadow [16];
  int         n_vec = 0, n_err = 0;
  bit         cpu_gnt_seen, ldr_gnt_seen;

  function automatic void model_reset();
    cpu_wait   = 0;
    ldr_wait   = 0;
    exp_owner  = 0;
    exp_cpu_rv = 0;
    exp_ldr_rv = 0;
    last_addr  = 0;
    last_data  = 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cycle_check();
    int winner;
    bit lock;
    cpu_gnt_seen = CpuGnt;
    ldr_gnt_seen = LdrGnt;
    if (!ResetN) begin
      chk("rst_cpu_gnt", CpuGnt, 0);
      chk("rst_ldr_gnt", LdrGnt, 0);
      chk("rst_ram_en", RamEn, 0);
      chk("rst_ram_wren", RamWren, 0);
      chk("rst_owner", Owner, 0);
      chk("rst_cpu_rvalid", CpuRvalid, 0);
      chk("rst_ldr_rvalid", LdrRvalid, 0);
      chk("rst_ram_addr", RamAddr, 0);
      chk("rst_ram_data", RamData, 0);
      return;
    end
    lock = (exp_owner == 1) && cpu_lock && CpuReq;
`ifndef TRISC_ARB_LOCK_EN
    lock = 0;
`endif
    if (CpuReq && LdrReq) begin
      if (lock) winner = 1;
      else if (ldr_wait >= MW) winner = 2;
      else if (cpu_wait >= MW) winner = 1;
      else winner = (PL != 0) ? 2 : 1;
    end else if (CpuReq) winner = 1;
    else if (LdrReq) winner = 2;
    else winner = 0;

    chk("cpu_gnt", CpuGnt, winner == 1);
    chk("ldr_gnt", LdrGnt, winner == 2);
    chk("ram_en", RamEn, winner != 0);
    chk("ram_wren", RamWren, (winner == 1) ? CpuWe : (winner == 2) ? LdrWe : 1'b0);
    chk("ram_addr", RamAddr, (winner == 1) ? CpuAddr : (winner == 2) ? LdrAddr : last_addr);
    chk("ram_data", RamData, (winner == 1) ? CpuWdata : (winner == 2) ? LdrWdata : last_data);
    chk("owner", Owner, exp_owner);
    chk("cpu_rvalid", CpuRvalid, exp_cpu_rv);
    chk("ldr_rvalid", LdrRvalid, exp_ldr_rv);
    if (exp_cpu_rv) chk("cpu_rdata", CpuRdata, exp_rd);
    if (exp_ldr_rv) chk("ldr_rdata", LdrRdata, exp_rd);

    cpu_wait   = (CpuReq && winner != 1) ? ((cpu_wait < 15) ? cpu_wait + 1 : 15) : 0;
    ldr_wait   = (LdrReq && winner != 2) ? ((ldr_wait < 15) ? ldr_wait + 1 : 15) : 0;
    exp_owner  = winner;
    exp_cpu_rv = (winner == 1) && !CpuWe;
    exp_ldr_rv = (winner == 2) && !LdrWe;
    if (winner == 1) begin
      exp_rd    = shadow[CpuAddr];
      last_addr = CpuAddr;
      last_data = CpuWdata;
      if (CpuWe) shadow[CpuAddr] = CpuWdata;
    end else if (winner == 2) begin
      exp_rd    = shadow[LdrAddr];
      last_addr = LdrAddr;
      last_data = LdrWdata;
      if (LdrWe) shadow[LdrAddr] = LdrWdata;
    end
  endtask

  task automatic tick();
    @(negedge SysClock);
    cycle_check();
    @(posedge SysClock);
    #1;
  endtask

  task automatic rand_drive();
    if (!CpuReq || cpu_gnt_seen) begin
      CpuReq   = ($urandom_range(3) != 0);
      CpuWe    = 1'($urandom_range(1));
      CpuAddr  = 4'($urandom);
      CpuWdata = 8'($urandom);
    end else if ($urandom_range(15) == 0) begin
      CpuReq = 0;
    end
    if (!LdrReq || ldr_gnt_seen) begin
      LdrReq   = ($urandom_range(3) != 0);
      LdrWe    = 1'($urandom_range(1));
      LdrAddr  = 4'($urandom);
      LdrWdata = 8'($urandom);
    end else if ($urandom_range(15) == 0) begin
      LdrReq = 0;
    end
    cpu_lock = ($urandom_range(3) == 0);
  endtask

  int exp_seq [5] = '{1, 1, 1, 2, 1};

  initial begin
    model_reset();
    #1 ResetN = 0;
    // Reset with both requesting, writes so no stale reads are involved
    CpuReq = 1; CpuWe = 1; CpuAddr = 4'h1; CpuWdata = 8'h11;
    LdrReq = 1; LdrWe = 1; LdrAddr = 4'h2; LdrWdata = 8'h22;
    tick();
    tick();
    ResetN = 1;
    // Continuous contention: CPU x3, then starved loader, then CPU
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("seq_cpu_gnt", CpuGnt, exp_seq[i] == 1);
      chk("seq_ldr_gnt", LdrGnt, exp_seq[i] == 2);
      tick();
    end
    // Fill RAM from the loader; RAM[3] = A5
    CpuReq = 0;
    for (int i = 0; i < 16; i++) begin
      LdrReq = 1; LdrWe = 1; LdrAddr = 4'(i);
      LdrWdata = (i == 3) ? 8'hA5 : 8'(8'h40 + i);
      tick();
    end
    LdrReq = 0;
    // CPU read of address 3
    CpuReq = 1; CpuWe = 0; CpuAddr = 4'h3;
    #1;
    chk("rd_gnt", CpuGnt, 1);
    chk("rd_addr", RamAddr, 4'h3);
    chk("rd_wren", RamWren, 0);
    tick();
    CpuReq = 0;
    #1;
    chk("rd_rvalid", CpuRvalid, 1);
    chk("rd_rdata", CpuRdata, 8'hA5);
    tick();
    // Loader write then CPU read of the same address
    LdrReq = 1; LdrWe = 1; LdrAddr = 4'hF; LdrWdata = 8'h5C;
    tick();
    LdrReq = 0;
    CpuReq = 1; CpuWe = 0; CpuAddr = 4'hF;
    #1 chk("wr_ldr_rvalid", LdrRvalid, 0);
    tick();
    CpuReq = 0;
    #1;
    chk("raw_rvalid", CpuRvalid, 1);
    chk("raw_rdata", CpuRdata, 8'h5C);
    chk("raw_ldr_rvalid", LdrRvalid, 0);
    tick();
    // Reset held across the edge that would register a granted read
    CpuReq = 1; CpuWe = 0; CpuAddr = 4'h3;
    #1 chk("mid_gnt", CpuGnt, 1);
    @(negedge SysClock);
    cycle_check();
    #2 ResetN = 0;
    model_reset();
    CpuReq = 0;
    @(posedge SysClock);
    #1 ResetN = 1;
    #1 chk("mid_rvalid0", CpuRvalid, 0);
    tick();
    chk("mid_rvalid1", CpuRvalid, 0);
`ifdef TRISC_ARB_LOCK_EN
    tick();
    cpu_lock = 1;
    CpuReq = 1; CpuWe = 0; CpuAddr = 4'h2;
    LdrReq = 1; LdrWe = 0; LdrAddr = 4'h4;
    for (int i = 0; i < 8; i++) begin
      #1 chk("lock_ldr_gnt", LdrGnt, 0);
      tick();
    end
    cpu_lock = 0;
    #1 chk("unlock_ldr_gnt", LdrGnt, 1);
    tick();
    CpuReq = 0; LdrReq = 0;
    cpu_lock = 0;
`endif
    tick();
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
